// File: rtl/fb_arb_pkg.sv
// Shared types and constants for the FlexBus register-port arbiter and the
// register-file block it fronts.
package fb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RWAIT = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam int FB_AW   = 8;
    localparam int FB_DW   = 32;
    localparam int FB_NREG = 5;

endpackage

// File: rtl/fb_rr_pick.sv
// Combinational 2-way round-robin select: on a tie the port not recorded in
// last wins, otherwise the single requester is granted.
module fb_rr_pick
    import fb_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = PORT_A;
        if (req == 2'b11) begin
            gnt_id = ~last;
        end else if (req[PORT_B]) begin
            gnt_id = PORT_B;
        end
    end

endmodule

// File: rtl/fb_reg_arbiter.sv
// Two-port round-robin arbiter sharing one single-cycle-latency register-file
// port between the FlexBus front end (A) and a PL-side local master (B).
module fb_reg_arbiter
    import fb_arb_pkg::*;
#(
    parameter int AW   = FB_AW,
    parameter int DW   = FB_DW,
    parameter int NREG = FB_NREG
)
(
    input  logic          FB_CLK,
    input  logic          RST_n,
    input  logic          A_REQ,
    input  logic          A_WE,
    input  logic [AW-1:0] A_ADDR,
    input  logic [DW-1:0] A_WDATA,
    output logic          A_ACK,
    output logic          A_ERR,
    output logic [DW-1:0] A_RDATA,
    input  logic          B_REQ,
    input  logic          B_WE,
    input  logic [AW-1:0] B_ADDR,
    input  logic [DW-1:0] B_WDATA,
    output logic          B_ACK,
    output logic          B_ERR,
    output logic [DW-1:0] B_RDATA,
    output logic          REG_EN,
    output logic          REG_WE,
    output logic [AW-1:0] REG_ADDR,
    output logic [DW-1:0] REG_WDATA,
    input  logic [DW-1:0] REG_RDATA,
    output logic          BUSY,
    output arb_state_e    DBG_STATE
);

    // One extra bit so NREG up to 2**AW compares correctly as unsigned.
    localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

    arb_state_e    state, state_n;
    logic          load;
    logic          gnt_valid, gnt_id;
    logic          last_q, cur_q, we_q, err_q;
    logic          sel_we, sel_err;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    fb_rr_pick u_pick (
        .req       ({B_REQ, A_REQ}),
        .last      (last_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_comb begin
        sel_we    = (gnt_id == PORT_B) ? B_WE    : A_WE;
        sel_addr  = (gnt_id == PORT_B) ? B_ADDR  : A_ADDR;
        sel_wdata = (gnt_id == PORT_B) ? B_WDATA : A_WDATA;
        sel_err   = ({1'b0, sel_addr} >= NREG_W);
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_valid) begin
                    state_n = ISSUE;
                    load    = 1'b1;
                end
            end
            ISSUE:   state_n = (err_q || we_q) ? DONE : RWAIT;
            RWAIT:   state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(negedge FB_CLK or negedge RST_n) begin
        if (!RST_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // REG_* are launched on the grant edge so the strobe lines up with ISSUE.
    always_ff @(negedge FB_CLK or negedge RST_n) begin
        if (!RST_n) begin
            last_q    <= PORT_B;
            cur_q     <= PORT_A;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            REG_EN    <= 1'b0;
            REG_WE    <= 1'b0;
            REG_ADDR  <= '0;
            REG_WDATA <= '0;
            A_ACK     <= 1'b0;
            A_ERR     <= 1'b0;
            A_RDATA   <= '0;
            B_ACK     <= 1'b0;
            B_ERR     <= 1'b0;
            B_RDATA   <= '0;
        end else begin
            REG_EN <= 1'b0;
            REG_WE <= 1'b0;
            if (load) begin
                cur_q  <= gnt_id;
                last_q <= gnt_id;
                we_q   <= sel_we;
                err_q  <= sel_err;
                if (!sel_err) begin
                    REG_EN    <= 1'b1;
                    REG_WE    <= sel_we;
                    REG_ADDR  <= sel_addr;
                    REG_WDATA <= sel_wdata;
                end
            end

            if (state == RWAIT) begin
                if (cur_q == PORT_B) B_RDATA <= REG_RDATA;
                else                 A_RDATA <= REG_RDATA;
            end else if (state == ISSUE && err_q && !we_q) begin
                if (cur_q == PORT_B) B_RDATA <= '0;
                else                 A_RDATA <= '0;
            end

            A_ACK <= (state_n == DONE) && (cur_q == PORT_A);
            A_ERR <= (state_n == DONE) && (cur_q == PORT_A) && err_q;
            B_ACK <= (state_n == DONE) && (cur_q == PORT_B);
            B_ERR <= (state_n == DONE) && (cur_q == PORT_B) && err_q;
        end
    end

    assign BUSY      = (state != IDLE);
    assign DBG_STATE = state;

endmodule
